// File: rtl/lpif_ll_pkg.sv
// lpif_ll_pkg: logic-link word layout shared by the rx buffer and its benches.
package lpif_ll_pkg;
    localparam int LL_WIDTH      = 273;
    localparam int STATE_OFF     = 0;
    localparam int STATE_W       = 4;
    localparam int PROTID_OFF    = 4;
    localparam int PROTID_W      = 2;
    localparam int DATA_OFF      = 6;
    localparam int DATA_W        = 256;
    localparam int DVALID_OFF    = 262;
    localparam int DVALID_W      = 1;
    localparam int CRC_OFF       = 263;
    localparam int CRC_W         = 8;
    localparam int CRC_VALID_OFF = 271;
    localparam int CRC_VALID_W   = 1;
    localparam int VALID_OFF     = 272;
    localparam int VALID_W       = 1;

    typedef struct packed {
        logic                valid;
        logic                crc_valid;
        logic [CRC_W-1:0]    crc;
        logic                dvalid;
        logic [DATA_W-1:0]   data;
        logic [PROTID_W-1:0] protid;
        logic [STATE_W-1:0]  state;
    } ll_word_t;
endpackage

// File: rtl/lpif_ll_sync_fifo.sv
// lpif_ll_sync_fifo: show-ahead FIFO storage, pointers and occupancy count.
// Callers qualify push/pop; full/empty are judged from the count outside.
module lpif_ll_sync_fifo
    import lpif_ll_pkg::*;
#(
    parameter int WIDTH = LL_WIDTH,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
endmodule

// File: rtl/lpif_rx_ll_fifo.sv
// lpif_rx_ll_fifo: rx logic-link buffer feeding the unpacker, with credit
// return per consumed word, overflow detection and link-down flush.
module lpif_rx_ll_fifo
    import lpif_ll_pkg::*;
#(
    parameter int WIDTH = LL_WIDTH,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH+1)
) (
    input  logic             clk_wr,
    input  logic             rst_wr_n,
    input  logic             rx_online,
    input  logic             rxfifo_i_push,
    input  logic [WIDTH-1:0] rxfifo_i_data,
    output logic [WIDTH-1:0] rxfifo_upstream_data,
    output logic             user_upstream_valid,
    input  logic             user_upstream_ready,
    output logic             tx_credit_return,
    output logic [CNT_W-1:0] fifo_count,
    output logic             rx_overflow_sticky
);
    logic [WIDTH-1:0] head;
    logic             full, pop, accept;

    assign user_upstream_valid  = fifo_count != '0;
    assign full                 = fifo_count == CNT_W'(DEPTH);
    assign pop                  = user_upstream_valid & user_upstream_ready;
    // a full FIFO still takes a word when the head leaves in the same cycle
    assign accept               = rx_online & rxfifo_i_push & (~full | pop);
    assign rxfifo_upstream_data = user_upstream_valid ? head : '0;

    lpif_ll_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk   (clk_wr),
        .rst_n (rst_wr_n),
        .flush (~rx_online),
        .push  (accept),
        .pop   (pop),
        .wdata (rxfifo_i_data),
        .rdata (head),
        .count (fifo_count)
    );

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            tx_credit_return   <= 1'b0;
            rx_overflow_sticky <= 1'b0;
        end else begin
            tx_credit_return <= rx_online & pop;
            if (!rx_online) rx_overflow_sticky <= 1'b0;
            else if (rxfifo_i_push & full & ~pop) rx_overflow_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lpif_rx_ll_fifo.sv
// tb_lpif_rx_ll_fifo: directed scenario tests for the rx logic-link buffer.
module tb_lpif_rx_ll_fifo;
    localparam int W = 273;

    logic         clk_wr = 1'b0;
    logic         rst_wr_n = 1'b0;
    logic         rx_online = 1'b1;
    logic         rxfifo_i_push = 1'b0;
    logic [W-1:0] rxfifo_i_data = '0;
    logic [W-1:0] rxfifo_upstream_data;
    logic         user_upstream_valid;
    logic         user_upstream_ready = 1'b0;
    logic         tx_credit_return;
    logic [3:0]   fifo_count;
    logic         rx_overflow_sticky;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk_wr = ~clk_wr;

    lpif_rx_ll_fifo dut (
        .clk_wr               (clk_wr),
        .rst_wr_n             (rst_wr_n),
        .rx_online            (rx_online),
        .rxfifo_i_push        (rxfifo_i_push),
        .rxfifo_i_data        (rxfifo_i_data),
        .rxfifo_upstream_data (rxfifo_upstream_data),
        .user_upstream_valid  (user_upstream_valid),
        .user_upstream_ready  (user_upstream_ready),
        .tx_credit_return     (tx_credit_return),
        .fifo_count           (fifo_count),
        .rx_overflow_sticky   (rx_overflow_sticky)
    );

    task automatic step();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({user_upstream_valid, tx_credit_return, rx_overflow_sticky} !== 3'b000 ||
            fifo_count !== 4'd0 || rxfifo_upstream_data !== '0) begin
            n_fail++;
            $display("FAIL reset: valid=%0b credit=%0b ovf=%0b count=%0d data=%0h, want all 0",
                     user_upstream_valid, tx_credit_return, rx_overflow_sticky, fifo_count, rxfifo_upstream_data);
        end
        step();
        rst_wr_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        rxfifo_i_push = 1'b1; rxfifo_i_data = W'(1); user_upstream_ready = 1'b1;
        step();
        rxfifo_i_push = 1'b0;
        n_cmp++;
        if (user_upstream_valid !== 1'b1 || rxfifo_upstream_data !== W'(1) || tx_credit_return !== 1'b0) begin
            n_fail++;
            $display("FAIL single_head: valid=%0b data=%0h credit=%0b, want 1/1/0",
                     user_upstream_valid, rxfifo_upstream_data, tx_credit_return);
        end
        step();
        n_cmp++;
        if (tx_credit_return !== 1'b1 || fifo_count !== 4'd0 || user_upstream_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_credit: credit=%0b count=%0d valid=%0b, want 1/0/0",
                     tx_credit_return, fifo_count, user_upstream_valid);
        end
        step();
        n_cmp++;
        if (tx_credit_return !== 1'b0) begin
            n_fail++;
            $display("FAIL single_credit_end: credit=%0b, want 0", tx_credit_return);
        end
        user_upstream_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int credits = 0;
        for (int i = 0; i < 8; i++) begin
            rxfifo_i_push = 1'b1; rxfifo_i_data = W'(32'hA0 + i);
            step();
            credits += int'(tx_credit_return);
        end
        rxfifo_i_data = W'(32'hFF);
        step();
        rxfifo_i_push = 1'b0;
        n_cmp++;
        if (fifo_count !== 4'd8 || rx_overflow_sticky !== 1'b1 || credits != 0 ||
            rxfifo_upstream_data !== W'(32'hA0)) begin
            n_fail++;
            $display("FAIL overflow: count=%0d ovf=%0b credits=%0d head=%0h, want 8/1/0/a0",
                     fifo_count, rx_overflow_sticky, credits, rxfifo_upstream_data);
        end
        user_upstream_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (user_upstream_valid !== 1'b1 || rxfifo_upstream_data !== W'(32'hA0 + i)) begin
                n_fail++;
                $display("FAIL drain[%0d]: valid=%0b data=%0h, want 1/%0h",
                         i, user_upstream_valid, rxfifo_upstream_data, 32'hA0 + i);
            end
            step();
            n_cmp++;
            if (tx_credit_return !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_credit[%0d]: credit=%0b, want 1", i, tx_credit_return);
            end
        end
        user_upstream_ready = 1'b0;
        step();
        n_cmp++;
        if (fifo_count !== 4'd0 || tx_credit_return !== 1'b0 || rx_overflow_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_end: count=%0d credit=%0b ovf=%0b, want 0/0/1",
                     fifo_count, tx_credit_return, rx_overflow_sticky);
        end
    endtask

    task automatic test_full_push_pop();
        logic [W-1:0] exp_q [$];
        rx_online = 1'b0;
        step();
        rx_online = 1'b1;
        n_cmp++;
        if (rx_overflow_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL offline_clears_ovf: ovf=%0b, want 0", rx_overflow_sticky);
        end
        for (int i = 0; i < 8; i++) begin
            rxfifo_i_push = 1'b1; rxfifo_i_data = W'(32'hC0 + i);
            step();
        end
        rxfifo_i_data = W'(32'hB0); user_upstream_ready = 1'b1;
        step();
        rxfifo_i_push = 1'b0;
        n_cmp++;
        if (fifo_count !== 4'd8 || rx_overflow_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL full_push_pop: count=%0d ovf=%0b, want 8/0", fifo_count, rx_overflow_sticky);
        end
        for (int i = 1; i < 8; i++) exp_q.push_back(W'(32'hC0 + i));
        exp_q.push_back(W'(32'hB0));
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (user_upstream_valid !== 1'b1 || rxfifo_upstream_data !== exp_q[i]) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: valid=%0b data=%0h, want 1/%0h",
                         i, user_upstream_valid, rxfifo_upstream_data, exp_q[i]);
            end
            step();
        end
        user_upstream_ready = 1'b0;
        n_cmp++;
        if (fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL full_drain_end: count=%0d, want 0", fifo_count);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int credits = 0;
        int bad_order = 0;
        int max_cnt = 0;
        user_upstream_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0 && rxfifo_upstream_data !== W'(i - 1)) bad_order++;
            rxfifo_i_push = 1'b1; rxfifo_i_data = W'(i);
            step();
            credits += int'(tx_credit_return);
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
        rxfifo_i_push = 1'b0;
        if (rxfifo_upstream_data !== W'(19)) bad_order++;
        step();
        credits += int'(tx_credit_return);
        user_upstream_ready = 1'b0;
        n_cmp++;
        if (bad_order != 0 || credits != 20 || max_cnt != 1 || fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL back_to_back: bad_order=%0d credits=%0d max_count=%0d count=%0d, want 0/20/1/0",
                     bad_order, credits, max_cnt, fifo_count);
        end
        step();
    endtask

    task automatic test_offline_flush();
        for (int i = 0; i < 5; i++) begin
            rxfifo_i_push = 1'b1; rxfifo_i_data = W'(32'hD0 + i);
            step();
        end
        rxfifo_i_push = 1'b0;
        n_cmp++;
        if (fifo_count !== 4'd5) begin
            n_fail++;
            $display("FAIL flush_load: count=%0d, want 5", fifo_count);
        end
        user_upstream_ready = 1'b1; rx_online = 1'b0;
        step();
        n_cmp++;
        if (fifo_count !== 4'd0 || user_upstream_valid !== 1'b0 || rxfifo_upstream_data !== '0 ||
            tx_credit_return !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: count=%0d valid=%0b data=%0h credit=%0b, want 0/0/0/0",
                     fifo_count, user_upstream_valid, rxfifo_upstream_data, tx_credit_return);
        end
        rxfifo_i_push = 1'b1; rxfifo_i_data = W'(32'h77);
        step();
        rxfifo_i_push = 1'b0; rx_online = 1'b1; user_upstream_ready = 1'b0;
        step();
        n_cmp++;
        if (fifo_count !== 4'd0 || user_upstream_valid !== 1'b0 || tx_credit_return !== 1'b0) begin
            n_fail++;
            $display("FAIL offline_push: count=%0d valid=%0b credit=%0b, want 0/0/0",
                     fifo_count, user_upstream_valid, tx_credit_return);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            rxfifo_i_push = 1'b1; rxfifo_i_data = W'(32'hE0 + i);
            step();
        end
        rxfifo_i_push = 1'b0; user_upstream_ready = 1'b1;
        step();
        n_cmp++;
        if (tx_credit_return !== 1'b1 || fifo_count !== 4'd2) begin
            n_fail++;
            $display("FAIL pre_reset: credit=%0b count=%0d, want 1/2", tx_credit_return, fifo_count);
        end
        #2 rst_wr_n = 1'b0;
        #1;
        n_cmp++;
        if ({user_upstream_valid, tx_credit_return, rx_overflow_sticky} !== 3'b000 ||
            fifo_count !== 4'd0 || rxfifo_upstream_data !== '0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%0b credit=%0b ovf=%0b count=%0d data=%0h, want all 0",
                     user_upstream_valid, tx_credit_return, rx_overflow_sticky, fifo_count, rxfifo_upstream_data);
        end
        user_upstream_ready = 1'b0;
        #1 rst_wr_n = 1'b1;
        step();
        rxfifo_i_push = 1'b1; rxfifo_i_data = W'(5);
        step();
        rxfifo_i_push = 1'b0;
        n_cmp++;
        if (user_upstream_valid !== 1'b1 || rxfifo_upstream_data !== W'(5) || fifo_count !== 4'd1) begin
            n_fail++;
            $display("FAIL post_reset_push: valid=%0b data=%0h count=%0d, want 1/5/1",
                     user_upstream_valid, rxfifo_upstream_data, fifo_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_offline_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/lpif_rx_ll_fifo.md
Name: lpif_rx_ll_fifo

Overview:
- Receive-side logic-link buffer. Sits directly upstream of the LPIF x8 asym1 full master rx unpacker and drives its 273-bit rxfifo_upstream_data bus.
- Accepts words pushed from the AIB channel, buffers them in a show-ahead FIFO and hands them to the user with a valid/ready handshake.
- Returns one credit pulse to the far-side transmitter per word consumed. Detects and flags overflow.

Parameters:
- WIDTH, 273, logic-link word width (state 4 + protid 2 + data 256 + dvalid 1 + crc 8 + crc_valid 1 + valid 1).
- DEPTH, 8, FIFO entries; power of two, 2..64.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clk_wr  in  1  single block clock.
- rst_wr_n  in  1  reset; asynchronous, active-low.
- rx_online  in  1  link up; low flushes the FIFO.
- rxfifo_i_push  in  1  incoming word strobe from channel.
- rxfifo_i_data  in  WIDTH  incoming word.
- rxfifo_upstream_data  out  WIDTH  head word to unpacker.
- user_upstream_valid  out  1  head word valid.
- user_upstream_ready  in  1  consumer accepts head word.
- tx_credit_return  out  1  one-cycle pulse per consumed word.
- fifo_count  out  CNT_W  current occupancy.
- rx_overflow_sticky  out  1  push was dropped while full.

Behaviour:
- Reset (rst_wr_n low, async): rd/wr pointers 0, fifo_count 0, user_upstream_valid 0, rxfifo_upstream_data 0, tx_credit_return 0, rx_overflow_sticky 0. Storage array is not reset.
- Push: on a clk_wr edge with rxfifo_i_push=1 and rx_online=1, write rxfifo_i_data at wr_ptr and advance wr_ptr mod DEPTH.
- Show-ahead output: user_upstream_valid = (fifo_count != 0), registered state only.
  - rxfifo_upstream_data = mem[rd_ptr] when valid, else all-zero.
  - Latency from push to valid: 1 cycle, i.e. visible the cycle after the push edge.
- Pop: occurs when user_upstream_valid & user_upstream_ready. rd_ptr advances mod DEPTH. The next entry appears the following cycle.
- Ready while not valid is ignored; no pop occurs.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push & pop.
- Full (count==DEPTH):
  - Push with no pop in the same cycle: word dropped, pointers unchanged, rx_overflow_sticky set to 1.
  - Push with a simultaneous pop: accepted, count stays DEPTH.
- Empty with simultaneous push and ready: no pop, because valid is 0. The word is pushed and valid rises next cycle. There is no fall-through bypass.
- tx_credit_return: registered; asserts exactly 1 cycle after each pop edge, for 1 cycle. Back-to-back pops give back-to-back pulses.
- rx_online low (synchronous flush):
  - Pointers and count go to 0 at the next edge; valid falls.
  - Pushes are ignored; no credits are generated, including a pop in the same cycle.
  - rx_overflow_sticky is cleared.
- Sticky overflow otherwise clears only on reset.
- Async reset mid-operation: all state clears immediately; no partial credit pulse survives.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from the count, not from pointer comparison.

Decomposition:
- Package lpif_ll_pkg holds:
  - LL_WIDTH=273.
  - Field offset/width localparams: STATE 0/4, PROTID 4/2, DATA 6/256, DVALID 262/1, CRC 263/8, CRC_VALID 271/1, VALID 272/1.
  - A packed struct matching those fields, for use by testbenches.
- One sub-module, lpif_ll_sync_fifo: pointers, storage and count.
  - The top level adds the output zero-masking, credit pulse, overflow sticky and rx_online flush.

Test Plan:
1. Reset, then push word 0x1 with ready=1 -> valid=1 and data=0x1 on cycle +1; pop at edge +1; tx_credit_return=1 on cycle +2 only; fifo_count back to 0.
2. ready=0, push 8 words 0xA0..0xA7 -> fifo_count=8, no credits. Push a 9th word 0xFF -> dropped, rx_overflow_sticky=1. Drain with ready=1 -> 0xA0..0xA7 in order, then 8 consecutive credit pulses.
3. Full FIFO; push 0xB0 and pop in the same cycle -> count stays 8, overflow stays 0, 0xB0 is delivered last.
4. Continuous push and pop for 20 words, 0..19 -> pointer wrap-around is transparent, output order is 0..19, 20 credit pulses, count never exceeds 1.
5. Load 5 words, drop rx_online for 1 cycle with ready=1 -> next cycle count=0, valid=0, data=0, no credit pulse. Push while offline -> ignored.
6. Load 3 words, assert rst_wr_n=0 asynchronously mid-cycle -> all outputs 0 immediately. Release, push 0x5 -> valid on the next cycle with data 0x5.
